// File: rtl/seg_codes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_codes_pkg
// Purpose  : Shared 7-segment letter codes, ASCII constants and scan FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package seg_codes_pkg;

    // Active-low patterns, bit 6..0 = g..a
    localparam logic [6:0] c_SEG_A     = 7'b0001000;
    localparam logic [6:0] c_SEG_B     = 7'b0000011;
    localparam logic [6:0] c_SEG_C     = 7'b1000110;
    localparam logic [6:0] c_SEG_D     = 7'b0100001;
    localparam logic [6:0] c_SEG_E     = 7'b0000110;
    localparam logic [6:0] c_SEG_F     = 7'b0001110;
    localparam logic [6:0] c_SEG_G     = 7'b1000010;
    localparam logic [6:0] c_SEG_H     = 7'b0001001;
    localparam logic [6:0] c_SEG_I     = 7'b1111001;
    localparam logic [6:0] c_SEG_K     = 7'b0001010;
    localparam logic [6:0] c_SEG_L     = 7'b1000111;
    localparam logic [6:0] c_SEG_N     = 7'b0101011;
    localparam logic [6:0] c_SEG_O     = 7'b1000000;
    localparam logic [6:0] c_SEG_P     = 7'b0001100;
    localparam logic [6:0] c_SEG_R     = 7'b0101111;
    localparam logic [6:0] c_SEG_S     = 7'b0010010;
    localparam logic [6:0] c_SEG_T     = 7'b0000111;
    localparam logic [6:0] c_SEG_U     = 7'b1000001;
    localparam logic [6:0] c_SEG_BLANK = 7'b1111111;

    localparam logic [7:0] c_ASCII_SPACE   = 8'h20;
    localparam logic [7:0] c_ASCII_UNKNOWN = 8'h3F;

    typedef enum logic [1:0] {
        ST_WAIT    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } scan_state_t;

    function automatic logic an_is_legal(input logic [3:0] an);
        return (an == 4'b1110) || (an == 4'b1101) ||
               (an == 4'b1011) || (an == 4'b0111);
    endfunction

    function automatic logic [1:0] an_to_digit(input logic [3:0] an);
        case (an)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_decoder_if
// Purpose  : Display bus observed by the decoder and the frames it publishes.
// Revision : 1.0 - initial release
// ============================================================================
interface seg_scan_decoder_if;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [31:0] char_out;
    logic        frame_valid;
    logic        frame_changed;
    logic        err;

    modport master (
        output seg, an,
        input  char_out, frame_valid, frame_changed, err
    );

    modport slave (
        input  seg, an,
        output char_out, frame_valid, frame_changed, err
    );
endinterface
`default_nettype wire

// File: rtl/seg_char_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg_char_decode
// Purpose  : Combinational active-low 7-segment pattern to ASCII decoder.
// Revision : 1.0 - initial release
// ============================================================================
module seg_char_decode
    import seg_codes_pkg::*;
(
    input  logic [6:0] seg,
    output logic [7:0] ascii,
    output logic       known
);

    // Z shares the S pattern on the encoder side, so it always reads back as S
    always_comb begin
        ascii = c_ASCII_UNKNOWN;
        known = 1'b1;
        case (seg)
            c_SEG_A:     ascii = "A";
            c_SEG_B:     ascii = "B";
            c_SEG_C:     ascii = "C";
            c_SEG_D:     ascii = "D";
            c_SEG_E:     ascii = "E";
            c_SEG_F:     ascii = "F";
            c_SEG_G:     ascii = "G";
            c_SEG_H:     ascii = "H";
            c_SEG_I:     ascii = "I";
            c_SEG_K:     ascii = "K";
            c_SEG_L:     ascii = "L";
            c_SEG_N:     ascii = "N";
            c_SEG_O:     ascii = "O";
            c_SEG_P:     ascii = "P";
            c_SEG_R:     ascii = "R";
            c_SEG_S:     ascii = "S";
            c_SEG_T:     ascii = "T";
            c_SEG_U:     ascii = "U";
            c_SEG_BLANK: ascii = c_ASCII_SPACE;
            default:     known = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_decoder
// Purpose  : Samples a multiplexed 4-digit display bus, decodes each digit
//            and publishes frames that repeat for STABLE_FRAMES scans.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_decoder
    import seg_codes_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int STABLE_FRAMES = 2
) (
    input  logic               clk,
    input  logic               rst,
    seg_scan_decoder_if.slave  bus
);

    localparam logic [7:0] c_SETTLE = 8'(SETTLE_CYCLES);
    localparam logic [3:0] c_STABLE = 4'(STABLE_FRAMES);

    scan_state_t     r_state;
    scan_state_t     w_state_next;
    logic [3:0]      r_an_prev;
    logic [6:0]      r_seg_prev;
    logic [7:0]      r_cnt;
    logic [7:0]      w_cnt_next;
    logic [7:0]      w_cnt_inc;
    logic [3:0]      r_cap_an;
    logic [3:0][7:0] r_cand;
    logic [3:0][7:0] r_prev_cand;
    logic [3:0][7:0] w_cand_next;
    logic [3:0]      r_mask;
    logic [3:0]      w_mask_next;
    logic [3:0]      r_agree;
    logic [3:0]      w_agree_inc;
    logic [3:0]      w_agree_next;
    logic [31:0]     r_char_out;
    logic            r_frame_valid;
    logic            r_frame_changed;
    logic            r_err;
    logic            w_stable;
    logic            w_an_legal;
    logic            w_wait_err;
    logic [1:0]      w_digit;
    logic [7:0]      w_ascii;
    logic            w_known;
    logic            w_frame_done;
    logic            w_publish;

    // The settled sample from the previous cycle is what gets captured
    seg_char_decode u_decode (
        .seg   (r_seg_prev),
        .ascii (w_ascii),
        .known (w_known)
    );

    assign w_stable   = (bus.an == r_an_prev) && (bus.seg == r_seg_prev);
    assign w_an_legal = an_is_legal(bus.an);
    assign w_cnt_inc  = (r_cnt < c_SETTLE) ? r_cnt + 8'd1 : r_cnt;
    assign w_digit    = an_to_digit(r_an_prev);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_wait_err   = 1'b0;
        case (r_state)
            ST_WAIT: begin
                if (w_an_legal) begin
                    w_state_next = ST_SETTLE;
                    w_cnt_next   = 8'd0;
                end
            end
            ST_SETTLE: begin
                if (!w_an_legal) begin
                    w_state_next = ST_WAIT;
                    w_wait_err   = (bus.an != 4'hF);
                end else if (w_stable) begin
                    w_cnt_next = w_cnt_inc;
                    if (w_cnt_inc == c_SETTLE) begin
                        w_state_next = ST_CAPTURE;
                    end
                end else begin
                    w_cnt_next = 8'd0;
                end
            end
            ST_CAPTURE: begin
                w_state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.an != r_cap_an) begin
                    if (w_an_legal) begin
                        w_state_next = ST_SETTLE;
                        w_cnt_next   = 8'd0;
                    end else begin
                        w_state_next = ST_WAIT;
                        w_wait_err   = (bus.an != 4'hF);
                    end
                end
            end
            default: begin
                w_state_next = ST_WAIT;
            end
        endcase
    end

    always_comb begin
        w_cand_next          = r_cand;
        w_cand_next[w_digit] = w_ascii;
        w_mask_next          = r_mask | (4'b0001 << w_digit);
        w_agree_inc          = (r_agree < c_STABLE) ? r_agree + 4'd1 : r_agree;
        w_agree_next         = (w_cand_next == r_prev_cand) ? w_agree_inc : 4'd1;
        w_frame_done         = (r_state == ST_CAPTURE) && (w_mask_next == 4'hF);
        w_publish            = w_frame_done && (w_agree_next == c_STABLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_WAIT;
            r_an_prev       <= 4'hF;
            r_seg_prev      <= c_SEG_BLANK;
            r_cnt           <= 8'd0;
            r_cap_an        <= 4'hF;
            r_cand          <= {4{c_ASCII_SPACE}};
            r_prev_cand     <= {4{c_ASCII_SPACE}};
            r_mask          <= 4'd0;
            r_agree         <= 4'd0;
            r_char_out      <= {4{c_ASCII_SPACE}};
            r_frame_valid   <= 1'b0;
            r_frame_changed <= 1'b0;
            r_err           <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_an_prev       <= bus.an;
            r_seg_prev      <= bus.seg;
            r_cnt           <= w_cnt_next;
            r_frame_valid   <= 1'b0;
            r_frame_changed <= 1'b0;
            r_err           <= w_wait_err;
            if (r_state == ST_CAPTURE) begin
                r_cap_an <= r_an_prev;
                r_cand   <= w_cand_next;
                r_mask   <= w_frame_done ? 4'd0 : w_mask_next;
                if (!w_known) begin
                    r_err <= 1'b1;
                end
                if (w_frame_done) begin
                    r_prev_cand <= w_cand_next;
                    r_agree     <= w_publish ? 4'd0 : w_agree_next;
                end
                if (w_publish) begin
                    r_char_out      <= w_cand_next;
                    r_frame_valid   <= 1'b1;
                    r_frame_changed <= (w_cand_next != r_char_out);
                end
            end
        end
    end

    assign bus.char_out      = r_char_out;
    assign bus.frame_valid   = r_frame_valid;
    assign bus.frame_changed = r_frame_changed;
    assign bus.err           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_decoder
// Purpose  : Self-checking bench for seg_scan_decoder with a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_decoder;

    localparam int SETTLE = 4;
    localparam int STABLE = 2;
    localparam int N_TBL  = 21;

    typedef struct {
        logic [6:0] seg;
        logic [7:0] ascii;
        bit         bad;
    } vec_t;

    typedef logic [3:0][6:0] word_t;

    localparam logic [6:0] P_O = 7'b1000000;
    localparam logic [6:0] P_P = 7'b0001100;
    localparam logic [6:0] P_E = 7'b0000110;
    localparam logic [6:0] P_N = 7'b0101011;

    logic clk;
    logic rst;
    seg_scan_decoder_if sif ();

    seg_scan_decoder #(
        .SETTLE_CYCLES (SETTLE),
        .STABLE_FRAMES (STABLE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t        tbl [N_TBL];
    int          n_vec = 0;
    int          n_fail = 0;
    int          dut_fv = 0;
    int          dut_err = 0;
    int          exp_err = 0;
    logic        last_changed = 1'b0;
    logic [32:0] exp_q [$];

    // Reference model state: per-digit visit tracking and frame agreement
    logic [3:0]  m_prev_an;
    logic [6:0]  m_prev_seg;
    int          m_run;
    bit          m_done;
    bit          m_pend;
    logic [3:0]  m_pan;
    logic [6:0]  m_pseg;
    logic [7:0]  m_slot [4];
    logic [3:0]  m_mask;
    logic [31:0] m_prevc;
    logic [31:0] m_char;
    int          m_agree;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] m_decode(input logic [6:0] s, output bit bad);
        logic [7:0] ch;
        bad = 1'b1;
        ch  = "?";
        for (int i = 0; i < N_TBL; i++) begin
            if (!tbl[i].bad && tbl[i].seg == s) begin
                bad = 1'b0;
                ch  = tbl[i].ascii;
            end
        end
        return ch;
    endfunction

    task automatic m_reset();
        m_prev_an  = 4'hF;
        m_prev_seg = 7'h7F;
        m_run      = 0;
        m_done     = 1'b0;
        m_pend     = 1'b0;
        for (int i = 0; i < 4; i++) m_slot[i] = 8'h20;
        m_mask     = 4'd0;
        m_prevc    = 32'h20202020;
        m_char     = 32'h20202020;
        m_agree    = 0;
        exp_q.delete();
    endtask

    task automatic m_capture(input logic [3:0] a, input logic [6:0] s);
        int          idx;
        bit          bad;
        logic [31:0] cand;
        idx = 0;
        for (int i = 0; i < 4; i++) if (!a[i]) idx = i;
        m_slot[idx] = m_decode(s, bad);
        if (bad) exp_err++;
        m_mask[idx] = 1'b1;
        if (m_mask == 4'hF) begin
            cand = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
            if (cand == m_prevc) m_agree = (m_agree < STABLE) ? m_agree + 1 : m_agree;
            else m_agree = 1;
            m_prevc = cand;
            m_mask  = 4'd0;
            if (m_agree == STABLE) begin
                exp_q.push_back({(cand != m_char), cand});
                m_char  = cand;
                m_agree = 0;
            end
        end
    endtask

    task automatic model_step();
        logic [3:0] a;
        logic [6:0] s;
        bit         legal;
        a = sif.an;
        s = sif.seg;
        if (rst) begin
            m_reset();
            return;
        end
        if (m_pend) begin
            m_capture(m_pan, m_pseg);
            m_pend = 1'b0;
        end
        legal = ($countones(~a) == 1);
        if (!legal && a != 4'hF && $countones(~m_prev_an) == 1) exp_err++;
        if (a != m_prev_an) m_done = 1'b0;
        if (legal && a == m_prev_an && s == m_prev_seg) m_run++;
        else m_run = 0;
        if (legal && m_run == SETTLE && !m_done) begin
            m_pend = 1'b1;
            m_pan  = a;
            m_pseg = s;
            m_done = 1'b1;
        end
        m_prev_an  = a;
        m_prev_seg = s;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (sif.err === 1'b1) dut_err++;
            if (sif.frame_valid === 1'b1) begin
                dut_fv++;
                last_changed = sif.frame_changed;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL publish_unexpected: actual char_out %h, required no publish", sif.char_out);
                end else begin
                    e = exp_q.pop_front();
                    check("publish_char", sif.char_out, e[31:0]);
                    check("publish_changed", 32'(sif.frame_changed), 32'(e[32]));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            sif.an  = 4'hF;
            sif.seg = 7'h7F;
            tick();
        end
    endtask

    task automatic show_raw(input logic [3:0] a, input logic [6:0] p, input int n);
        for (int i = 0; i < n; i++) begin
            sif.an  = a;
            sif.seg = p;
            tick();
        end
    endtask

    // g > 0 inverts the segments for one cycle at that offset into the dwell
    task automatic show(input int d, input logic [6:0] p, input int n, input int g);
        logic [3:0] one;
        one = 4'b0001 << d;
        for (int i = 0; i < n; i++) begin
            sif.an  = ~one;
            sif.seg = (g > 0 && i == g) ? ~p : p;
            tick();
        end
    endtask

    task automatic scan(input word_t w, input int dwell);
        for (int d = 0; d < 4; d++) show(d, w[d], dwell, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_char_out"}, sif.char_out, 32'h20202020);
        check({tag, "_frame_valid"}, 32'(sif.frame_valid), 32'd0);
        check({tag, "_frame_changed"}, 32'(sif.frame_changed), 32'd0);
        check({tag, "_err"}, 32'(sif.err), 32'd0);
    endtask

    task automatic random_phase(input int n_words);
        word_t w;
        int    reps;
        int    sel;
        int    dw;
        int    g;
        for (int k = 0; k < n_words; k++) begin
            for (int d = 0; d < 4; d++) begin
                if ($urandom % 10 == 0) w[d] = 7'($urandom);
                else w[d] = tbl[$urandom % 19].seg;
            end
            reps = 1 + int'($urandom % 4);
            for (int r = 0; r < reps; r++) begin
                for (int d = 0; d < 4; d++) begin
                    sel = int'($urandom % 10);
                    if (sel == 0) dw = 2;
                    else if (sel == 1) dw = SETTLE;
                    else dw = SETTLE + 5 + int'($urandom % 8);
                    g = (dw >= SETTLE + 5 && $urandom % 4 == 0) ? 1 : 0;
                    show(d, w[d], dw, g);
                end
            end
            if ($urandom % 5 == 0) idle(1 + int'($urandom % 3));
        end
    endtask

    initial begin
        word_t open_w;
        word_t w;
        int    fv0;
        int    e0;

        tbl[0]  = '{7'b0001000, "A", 1'b0};
        tbl[1]  = '{7'b0000011, "B", 1'b0};
        tbl[2]  = '{7'b1000110, "C", 1'b0};
        tbl[3]  = '{7'b0100001, "D", 1'b0};
        tbl[4]  = '{7'b0000110, "E", 1'b0};
        tbl[5]  = '{7'b0001110, "F", 1'b0};
        tbl[6]  = '{7'b1000010, "G", 1'b0};
        tbl[7]  = '{7'b0001001, "H", 1'b0};
        tbl[8]  = '{7'b1111001, "I", 1'b0};
        tbl[9]  = '{7'b0001010, "K", 1'b0};
        tbl[10] = '{7'b1000111, "L", 1'b0};
        tbl[11] = '{7'b0101011, "N", 1'b0};
        tbl[12] = '{7'b1000000, "O", 1'b0};
        tbl[13] = '{7'b0001100, "P", 1'b0};
        tbl[14] = '{7'b0101111, "R", 1'b0};
        tbl[15] = '{7'b0010010, "S", 1'b0};
        tbl[16] = '{7'b0000111, "T", 1'b0};
        tbl[17] = '{7'b1000001, "U", 1'b0};
        tbl[18] = '{7'b1111111, " ", 1'b0};
        tbl[19] = '{7'b0110110, "?", 1'b1};
        tbl[20] = '{7'b1111110, "?", 1'b1};

        open_w  = {P_N, P_E, P_P, P_O};
        rst     = 1'b1;
        sif.an  = 4'hF;
        sif.seg = 7'h7F;
        do_reset();
        check_reset_outputs("reset");

        // OPEN twice: first publish
        fv0 = dut_fv;
        scan(open_w, 20);
        scan(open_w, 20);
        idle(3);
        check("open_fv_count", dut_fv - fv0, 1);
        check("open_char", sif.char_out, 32'h4E45504F);
        check("open_changed", 32'(last_changed), 32'd1);

        // Same text again: republish without change
        fv0 = dut_fv;
        scan(open_w, 20);
        scan(open_w, 20);
        idle(3);
        check("repub_fv_count", dut_fv - fv0, 1);
        check("repub_char", sif.char_out, 32'h4E45504F);
        check("repub_changed", 32'(last_changed), 32'd0);

        // Digits too short to settle
        do_reset();
        fv0 = dut_fv;
        for (int i = 0; i < 4; i++) scan(open_w, 3);
        idle(3);
        check("short_fv_count", dut_fv - fv0, 0);
        check("short_char", sif.char_out, 32'h20202020);

        // Two anodes low at once
        e0 = dut_err;
        show(0, P_O, 20, 0);
        show_raw(4'b1100, P_O, 10);
        idle(3);
        check("illegal_an_err", dut_err - e0, 1);

        // Reset after three of four digits
        do_reset();
        scan(open_w, 20);
        scan(open_w, 20);
        for (int d = 0; d < 3; d++) show(d, open_w[d], 20, 0);
        rst = 1'b1;
        idle(2);
        check_reset_outputs("midrst");
        rst = 1'b0;
        fv0 = dut_fv;
        scan(open_w, 20);
        idle(2);
        check("midrst_one_frame_fv", dut_fv - fv0, 0);
        scan(open_w, 20);
        idle(3);
        check("midrst_two_frame_fv", dut_fv - fv0, 1);
        check("midrst_char", sif.char_out, 32'h4E45504F);
        check("midrst_changed", 32'(last_changed), 32'd1);

        // Decode table through slot 2
        do_reset();
        for (int i = 0; i < N_TBL; i++) begin
            fv0 = dut_fv;
            e0  = dut_err;
            w   = {P_N, tbl[i].seg, P_P, P_O};
            scan(w, SETTLE + 3);
            scan(w, SETTLE + 3);
            idle(3);
            check($sformatf("tbl%0d_fv", i), dut_fv - fv0, 1);
            check($sformatf("tbl%0d_char", i), {24'd0, sif.char_out[23:16]}, {24'd0, tbl[i].ascii});
            check($sformatf("tbl%0d_err", i), dut_err - e0, tbl[i].bad ? 2 : 0);
        end

        random_phase(40);
        idle(5);
        check("model_queue_empty", exp_q.size(), 0);
        check("err_total", dut_err, exp_err);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Observer for the multiplexed 4-digit 7-segment bus driven by the restaurant display. Samples the active-low `seg`/`an` lines, waits for each digit strobe to settle, decodes each segment pattern back to an ASCII character, and assembles the four digits into a frame. It publishes a frame only after it repeats identically for a set number of scans. The block is the decode end of the display interface: it feeds the self-check logic and the on-board loopback test, and gives any downstream consumer the text currently shown.

## Interface
- `SETTLE_CYCLES`, 4: consecutive cycles `an` and `seg` must hold unchanged before a digit is sampled (1..255).
- `STABLE_FRAMES`, 2: identical complete frames required before publishing (1..15).

- `clk`  in  1  system clock (100 MHz).
- `rst`  in  1  reset; one clock domain, reset is synchronous and active-high.
- `seg`  in  7  segment lines a..g, bit 0 = a, active-low.
- `an`  in  4  digit anodes, active-low; `1110` = digit 0 … `0111` = digit 3.
- `char_out`  out  32  published frame; [7:0] = digit 0 … [31:24] = digit 3, ASCII.
- `frame_valid`  out  1  one-cycle pulse when `char_out` is (re)published.
- `frame_changed`  out  1  one-cycle pulse, coincident with `frame_valid`, when the published frame differs from the previous one.
- `err`  out  1  one-cycle pulse on an illegal anode pattern or an unknown segment pattern.

## Operation
- Decode table (pattern → ASCII):
  - A 0001000, B 0000011, C 1000110, D 0100001, E 0000110, F 0001110, G 1000010, H 0001001, I 1111001, K 0001010, L 1000111, N 0101011, O 1000000, P 0001100, R 0101111, S 0010010, T 0000111, U 1000001.
  - Blank 1111111 → " ".
  - 0010010 decodes to "S". The encoder maps Z to the same pattern, so this ambiguity is accepted.
  - Any other pattern → "?", with an `err` pulse.
- Sampler FSM:
  - **WAIT**: `an` is not exactly one-low. Sit here; pulse `err` once on entry if `an` is not `1111`.
  - **SETTLE**: counter increments while `an` and `seg` both equal their last-cycle values. Any change reloads the counter to 0. If `an` becomes illegal, go to WAIT.
  - **CAPTURE**: one cycle. Store the decoded character in the slot for the active digit and set its mask bit. Go to **HOLD**.
  - **HOLD**: stay until `an` changes. Then go to SETTLE (legal `an`) or WAIT (illegal `an`). A segment change alone, with the same anode, causes no recapture.
- Frame assembly:
  - A capture into an already-set slot overwrites the slot; the mask is unchanged.
  - When the mask reaches `1111`, compare the 4-slot candidate with the previous candidate.
    - Equal: `agree_cnt` increments, saturating at `STABLE_FRAMES`.
    - Otherwise: `agree_cnt` = 1.
  - Then clear the mask.
  - When `agree_cnt` reaches `STABLE_FRAMES`:
    - load `char_out` and pulse `frame_valid`;
    - pulse `frame_changed` if the new value differs from the old `char_out`;
    - reset `agree_cnt` to 0, so a static display republishes every `STABLE_FRAMES` frames.
- Simultaneous events: frame completion and a new SETTLE start in the same cycle are independent; both proceed.

## Timing
- Reset values:
  - `char_out` = 32'h20202020 (four spaces);
  - `frame_valid` = 0, `frame_changed` = 0, `err` = 0;
  - FSM in WAIT, mask 0, `agree_cnt` 0, candidate = spaces.
- `rst` mid-frame discards partial captures and the agreement count. The first publish after reset needs a full `STABLE_FRAMES` run.
- Digit sample latency: CAPTURE occurs on the cycle after `SETTLE_CYCLES` stable cycles following the anode change.
- Publish latency: the slot write and completion check happen in the CAPTURE cycle. `char_out`, `frame_valid` and `frame_changed` update on the next edge.
- All outputs are registered. There are no combinational paths from `seg`/`an` to outputs.
- The settle counter is 8 bits and must not wrap: it saturates at `SETTLE_CYCLES`.

## Structure
- Package `seg_codes_pkg` holds:
  - segment-pattern localparams per letter and blank, shared with the display encoder;
  - ASCII constants for space and "?";
  - the FSM state enum (WAIT/SETTLE/CAPTURE/HOLD).
- Sub-module `seg_char_decode` (combinational): `seg[6:0]` → `{ascii[7:0], known}`. It is reused by the display self-check.
- The top level holds the FSM, settle counter, 4-slot candidate, mask, agreement counter and output registers.

## Test plan
- Drive "OPEN" with `SETTLE_CYCLES`=4, `STABLE_FRAMES`=2, 20 cycles per digit, for 2 full scans → `frame_valid` pulses once; `char_out` = "NEPO" read [31:24]..[7:0] ("O" in [7:0]); `frame_changed`=1.
- Continue the same frames for 2 more scans → `frame_valid` pulses again; `frame_changed`=0.
- Hold each digit only 3 cycles → no captures and no `frame_valid`; `char_out` stays at spaces.
- Drive `an`=1100 for 10 cycles → exactly one `err` pulse; no slot is written.
- Digit 2 shows 0110110 → slot 2 = "?"; `err` pulses once per capture. Separately, 0010010 → "S".
- Assert `rst` after 3 of 4 digits → outputs return to reset values; the next publish requires 2 new complete frames.
